// File: rtl/esl_clk_check_cut_counter.sv
// Clock-under-test cycle counter gated by a synchronized reference window; producer side of the clock-frequency check.
// Optional build macro ESL_CUT_COUNT_PARITY_EN adds cut_count_par and par_error.
module esl_clk_check_cut_counter #(
  parameter int BIT_WD      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic            cut_clk,
  input  logic            cut_rst,
  input  logic            meas_en,
  input  logic            ref_window,
  output logic [BIT_WD:0] cut_count_end_val,
  output logic            cut_count_valid,
  output logic            cut_count_ovf,
  output logic            cut_count_busy
`ifdef ESL_CUT_COUNT_PARITY_EN
  ,
  output logic            cut_count_par,
  output logic            par_error
`endif
);

  localparam int NSYNC = ((SYNC_STAGES >= 2) && (SYNC_STAGES <= 4)) ? SYNC_STAGES : 2;
  localparam logic [2:0]      FLUSH_N = 3'(NSYNC);
  localparam logic [BIT_WD:0] CNT_MAX = {(BIT_WD+1){1'b1}};
  localparam logic [BIT_WD:0] CNT_ONE = {{BIT_WD{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_e;

  function automatic logic even_par(input logic ovf, input logic [BIT_WD:0] val);
    return ovf ^ (^val);
  endfunction

  state_e          state_q;
  logic [NSYNC-1:0] sync_q;
  logic            win_d_q;
  logic [2:0]      flush_q;
  logic [BIT_WD:0] cnt_q;
  logic [BIT_WD:0] cnt_d;
  logic            ovf_int_q;
  logic [BIT_WD:0] end_val_q;
  logic            ovf_q;
  logic            valid_q;
  logic            par_q;
  logic            par_err_q;
  logic            win_s;
  logic            rise;
  logic            fall;

  assign win_s = sync_q[NSYNC-1];
  assign rise  = win_s & ~win_d_q;
  assign fall  = ~win_s & win_d_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge cut_clk or posedge cut_rst) begin
    if (cut_rst) begin
      sync_q  <= '0;
      win_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[NSYNC-2:0], ref_window};
      win_d_q <= win_s;
    end
  end

  // flush_q keeps IDLE from arming until the synchronizer holds real samples,
  // so a window already high at reset release or enable is never measured.
  always_ff @(posedge cut_clk or posedge cut_rst) begin
    if (cut_rst) begin
      state_q   <= IDLE;
      flush_q   <= 3'd0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      end_val_q <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!meas_en) begin
        state_q   <= IDLE;
        flush_q   <= 3'd0;
        cnt_q     <= '0;
        ovf_int_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (flush_q != FLUSH_N) begin
              flush_q <= flush_q + 3'd1;
            end else if (!win_s) begin
              state_q <= ARMED;
            end else begin
              state_q <= IDLE;
            end
          end
          ARMED: begin
            if (rise) begin
              state_q   <= COUNT;
              cnt_q     <= CNT_ONE;
              ovf_int_q <= 1'b0;
            end else begin
              state_q <= ARMED;
            end
          end
          COUNT: begin
            if (win_s) begin
              cnt_q <= cnt_d;
              if (cnt_d == CNT_MAX) begin
                ovf_int_q <= 1'b1;
              end else begin
                ovf_int_q <= ovf_int_q;
              end
            end else if (fall) begin
              end_val_q <= cnt_q;
              ovf_q     <= ovf_int_q;
              par_q     <= even_par(ovf_int_q, cnt_q);
              valid_q   <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ARMED;
            end else begin
              state_q <= COUNT;
            end
          end
          default: begin
            state_q <= IDLE;
            flush_q <= 3'd0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Recompute parity of the held result every cycle to catch register upsets.
  always_ff @(posedge cut_clk or posedge cut_rst) begin
    if (cut_rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= even_par(ovf_q, end_val_q) ^ par_q;
    end
  end

  assign cut_count_end_val = end_val_q;
  assign cut_count_valid   = valid_q;
  assign cut_count_ovf     = ovf_q;
  assign cut_count_busy    = (state_q == COUNT);

`ifdef ESL_CUT_COUNT_PARITY_EN
  assign cut_count_par = par_q;
  assign par_error     = par_err_q;
`else
  logic unused_par_s;
  assign unused_par_s = par_q ^ par_err_q;
`endif

endmodule

// File: tb/tb_esl_clk_check_cut_counter.sv
// Randomized scoreboard bench: a default-width instance and a BIT_WD=3 instance share the same stimulus.
module tb_esl_clk_check_cut_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        win;
  logic [24:0] end0;
  logic        vld0, ovf0, busy0;
  logic [3:0]  end3;
  logic        vld3, ovf3, busy3;
`ifdef ESL_CUT_COUNT_PARITY_EN
  logic        par0, perr0, par3, perr3;
`endif

  esl_clk_check_cut_counter dut (
    .cut_clk(clk), .cut_rst(rst), .meas_en(en), .ref_window(win),
    .cut_count_end_val(end0), .cut_count_valid(vld0), .cut_count_ovf(ovf0), .cut_count_busy(busy0)
`ifdef ESL_CUT_COUNT_PARITY_EN
    , .cut_count_par(par0), .par_error(perr0)
`endif
  );

  esl_clk_check_cut_counter #(.BIT_WD(3)) dut3 (
    .cut_clk(clk), .cut_rst(rst), .meas_en(en), .ref_window(win),
    .cut_count_end_val(end3), .cut_count_valid(vld3), .cut_count_ovf(ovf3), .cut_count_busy(busy3)
`ifdef ESL_CUT_COUNT_PARITY_EN
    , .cut_count_par(par3), .par_error(perr3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] v;
    logic        o;
    int          c;
  } exp_t;

  exp_t        q0[$];
  exp_t        q3[$];
  logic [24:0] last_end[2];
  logic        last_ovf[2];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          chk_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reference model: a window sampled high for n edges yields min(n, max) and overflow once max is reached.
  function automatic exp_t model(input int n, input int bw, input int c);
    exp_t e;
    longint maxv;
    maxv = (64'sd1 <<< (bw + 1)) - 1;
    e.v  = (n > maxv) ? 25'(maxv) : 25'(n);
    e.o  = (n >= maxv);
    e.c  = c;
    return e;
  endfunction

  task automatic mon(input int id, input logic vld, input logic [24:0] ev, input logic ov);
    exp_t e;
    string nm;
    nm = (id == 0) ? "w25" : "w4";
    if (vld) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q3.size() == 0)) begin
        chk({nm, "_unexpected_valid"}, 32'd1, 32'd0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q3.pop_front();
        chk({nm, "_end_val"}, 32'(ev), 32'(e.v));
        chk({nm, "_ovf"}, 32'(ov), 32'(e.o));
        chk({nm, "_latency"}, 32'(cyc), 32'(e.c));
`ifdef ESL_CUT_COUNT_PARITY_EN
        if (id == 0) chk("par", 32'(par0), 32'(e.o ^ (^e.v)));
`endif
        last_end[id] = e.v;
        last_ovf[id] = e.o;
      end
    end else begin
      chk({nm, "_hold_end"}, 32'(ev), 32'(last_end[id]));
      chk({nm, "_hold_ovf"}, 32'(ov), 32'(last_ovf[id]));
    end
  endtask

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      mon(0, vld0, end0, ovf0);
      mon(1, vld3, {21'd0, end3}, ovf3);
`ifdef ESL_CUT_COUNT_PARITY_EN
      chk("par_error_idle", 32'(perr0), 32'd0);
`endif
    end
  end

  // Window of n sampled-high cycles; valid expected NSYNC+1 edges after the drop is sampled.
  task automatic window(input int n, input bit expect_v, input int gap);
    win = 1'b1;
    if (n >= 8) begin
      tick(n / 2);
      chk("busy_mid", 32'(busy0), 32'(expect_v));
      chk("busy3_mid", 32'(busy3), 32'(expect_v));
      tick(n - n / 2);
    end else begin
      tick(n);
    end
    win = 1'b0;
    if (expect_v) begin
      q0.push_back(model(n, 24, cyc + 3));
      q3.push_back(model(n, 3, cyc + 3));
    end
    tick(gap);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    last_end = '{25'd0, 25'd0};
    last_ovf = '{1'b0, 1'b0};
    rst = 1'b1; en = 1'b0; win = 1'b0;
    #1;
    chk("rst_end", 32'(end0), 32'd0);
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    tick(3);
    rst = 1'b0; en = 1'b1;
    tick(6);
    window(100, 1'b1, 8);
    window(1, 1'b1, 8);
    window(20, 1'b1, 8);
    window(5, 1'b1, 8);

    // Disable in the very cycle the fall is seen: disable wins, no valid.
    win = 1'b1; tick(10); win = 1'b0; tick(2); en = 1'b0; tick(6); en = 1'b1; tick(6);

    // Disable at cycle 30 of a 60-cycle window.
    win = 1'b1; tick(30); en = 1'b0; tick(30); win = 1'b0; tick(6); en = 1'b1; tick(6);
    window(40, 1'b1, 8);

    // Window already high when reset releases.
    @(negedge clk); rst = 1'b1; win = 1'b1;
    last_end = '{25'd0, 25'd0}; last_ovf = '{1'b0, 1'b0};
    tick(2); rst = 1'b0;
    tick(10);
    chk("partial_busy", 32'(busy0), 32'd0);
    tick(10); win = 1'b0; tick(8);
    window(50, 1'b1, 8);

    // Asynchronous reset mid-count.
    win = 1'b1; tick(10); #2;
    rst = 1'b1;
    last_end = '{25'd0, 25'd0}; last_ovf = '{1'b0, 1'b0};
    #1;
    chk("arst_end", 32'(end0), 32'd0);
    chk("arst_ovf", 32'(ovf0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_valid", 32'(vld0), 32'd0);
    chk("arst_end3", 32'(end3), 32'd0);
    @(negedge clk); win = 1'b0; tick(3); rst = 1'b0; tick(6);
    window(7, 1'b1, 8);

    for (int i = 0; i < 16; i++) begin
      n = $urandom_range(1, 60);
      if ($urandom_range(0, 3) == 0 && n >= 4) begin
        k = $urandom_range(1, n - 1);
        win = 1'b1; tick(k); en = 1'b0; tick(n - k); win = 1'b0; tick(6); en = 1'b1; tick(6);
      end else begin
        window(n, 1'b1, $urandom_range(6, 10));
      end
    end

`ifdef ESL_CUT_COUNT_PARITY_EN
    window(7, 1'b1, 8);
    chk("par_7", 32'(par0), 32'd1);
    chk("par_err_7", 32'(perr0), 32'd0);
    chk_en = 1'b0;
    force dut.end_val_q[0] = 1'b0;
    tick(2);
    chk("par_err_flip", 32'(perr0), 32'd1);
    release dut.end_val_q[0];
`endif

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
